// File: rtl/clock_divider_controller_if.sv
// Configuration channel of the clock divider: one ratio update per valid/ready transfer.
// The requester drives valid/channel/division; the controller returns ready.
interface clock_divider_controller_if #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_W-1:0]      cfg_channel;
    logic [DIV_WIDTH-1:0] cfg_division;

    modport master (
        output cfg_valid,
        output cfg_channel,
        output cfg_division,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_channel,
        input  cfg_division,
        output cfg_ready
    );
endinterface

// File: rtl/clock_divider_controller.sv
// Per-channel programmable clock divider; first tick lands `division` cycles after acceptance.
// cfg_ready drops combinationally while the addressed channel still has an uncommitted ratio change.
module clock_divider_controller #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic                      input_clock,
    input  logic                      reset_n,
    clock_divider_controller_if.slave cfg,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       output_clock,
    output logic [CHANNELS-1:0]       busy
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] ST_DISABLED    = 2'd0;
    localparam logic [1:0] ST_RUN         = 2'd1;
    localparam logic [1:0] ST_RUN_PENDING = 2'd2;

    localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] ZERO = '0;

    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] accept;

    // An out-of-range channel matches no sel bit, so it is accepted and dropped.
    assign cfg.cfg_ready = ~|(sel & busy);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            localparam logic [CH_W-1:0] IDX = CH_W'(i);

            logic [1:0]           state;
            logic [DIV_WIDTH-1:0] active;
            logic [DIV_WIDTH-1:0] pending;
            logic [DIV_WIDTH-1:0] count;
            logic                 oclk;
            logic                 term;

            assign sel[i]          = (cfg.cfg_channel == IDX);
            assign accept[i]       = cfg.cfg_valid & cfg.cfg_ready & sel[i];
            assign term            = (count == active);
            assign tick[i]         = (state != ST_DISABLED) & term;
            assign busy[i]         = (state == ST_RUN_PENDING);
            assign output_clock[i] = oclk;

            always_ff @(posedge input_clock or negedge reset_n) begin
                if (!reset_n) begin
                    state   <= ST_DISABLED;
                    active  <= ZERO;
                    pending <= ZERO;
                    count   <= ZERO;
                    oclk    <= 1'b0;
                end else begin
                    case (state)
                        ST_DISABLED: begin
                            if (accept[i] && cfg.cfg_division != ZERO) begin
                                active  <= cfg.cfg_division;
                                pending <= cfg.cfg_division;
                                count   <= ONE;
                                state   <= ST_RUN;
                            end
                        end
                        ST_RUN: begin
                            if (term) begin
                                count <= ONE;
                                oclk  <= ~oclk;
                            end else begin
                                count <= count + ONE;
                            end
                            if (accept[i]) begin
                                pending <= cfg.cfg_division;
                                state   <= ST_RUN_PENDING;
                            end
                        end
                        ST_RUN_PENDING: begin
                            // Commit only at a period boundary so no period is cut or stretched.
                            if (term) begin
                                oclk   <= ~oclk;
                                active <= pending;
                                if (pending != ZERO) begin
                                    count <= ONE;
                                    state <= ST_RUN;
                                end else begin
                                    count <= ZERO;
                                    state <= ST_DISABLED;
                                end
                            end else begin
                                count <= count + ONE;
                            end
                        end
                        default: begin
                            state <= ST_DISABLED;
                            count <= ZERO;
                        end
                    endcase
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_clock_divider_controller.sv
// Directed bench for clock_divider_controller: three channels so channel index 3 is out of range.
module tb_clock_divider_controller;
    localparam int CHANNELS  = 3;
    localparam int DIV_WIDTH = 8;

    logic                input_clock = 1'b0;
    logic                reset_n;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] output_clock;
    logic [CHANNELS-1:0] busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] tk [CHANNELS];
    logic [31:0] oc [CHANNELS];
    logic [31:0] bz [CHANNELS];

    int n_ticks;
    int first_tick;
    int second_tick;

    clock_divider_controller_if #(.CHANNELS(CHANNELS), .DIV_WIDTH(DIV_WIDTH)) cfg ();

    clock_divider_controller #(.CHANNELS(CHANNELS), .DIV_WIDTH(DIV_WIDTH)) dut (
        .input_clock  (input_clock),
        .reset_n      (reset_n),
        .cfg          (cfg),
        .tick         (tick),
        .output_clock (output_clock),
        .busy         (busy)
    );

    always #5 input_clock = ~input_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d);
        cfg.cfg_valid    = v;
        cfg.cfg_channel  = ch;
        cfg.cfg_division = d;
    endtask

    task automatic clear_rec();
        for (int c = 0; c < CHANNELS; c++) begin
            tk[c] = '0;
            oc[c] = '0;
            bz[c] = '0;
        end
    endtask

    task automatic sample(input int k);
        for (int c = 0; c < CHANNELS; c++) begin
            tk[c][k] = tick[c];
            oc[c][k] = output_clock[c];
            bz[c][k] = busy[c];
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 8'd0);
        clear_rec();

        // Reset state
        repeat (2) @(negedge input_clock);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_oclk", 32'(output_clock), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        @(negedge input_clock);
        chk("ready_after_release", 32'(cfg.cfg_ready), 32'h1);

        // Basic divide by 3 on channel 0
        drive(1'b1, 2'd0, 8'd3);
        #1 chk("basic_ready", 32'(cfg.cfg_ready), 32'h1);
        clear_rec();
        for (int k = 1; k <= 12; k++) begin
            @(negedge input_clock);
            sample(k - 1);
            if (k == 1) cfg.cfg_valid = 1'b0;
        end
        chk("basic_tick0", tk[0], 32'h924);
        chk("basic_oclk0", oc[0], 32'hE38);

        // Glitch-free change on ch1, back-pressure, ch2 write in the pending window (ratio 1)
        drive(1'b1, 2'd1, 8'd4);
        clear_rec();
        for (int k = 1; k <= 14; k++) begin
            @(negedge input_clock);
            sample(k - 1);
            case (k)
                1: cfg.cfg_valid = 1'b0;
                2: begin
                    drive(1'b1, 2'd1, 8'd2);
                    #1 chk("ch1_ready_in_run", 32'(cfg.cfg_ready), 32'h1);
                end
                3: begin
                    drive(1'b1, 2'd1, 8'd3);
                    #1 chk("ch1_blocked_pending", 32'(cfg.cfg_ready), 32'h0);
                    drive(1'b1, 2'd2, 8'd1);
                    #1 chk("ch2_accepted_in_window", 32'(cfg.cfg_ready), 32'h1);
                end
                4: begin
                    drive(1'b1, 2'd1, 8'd3);
                    #1 chk("ch1_blocked_commit_cycle", 32'(cfg.cfg_ready), 32'h0);
                end
                5: chk("ch1_ready_after_commit", 32'(cfg.cfg_ready), 32'h1);
                6: cfg.cfg_valid = 1'b0;
                default: ;
            endcase
        end
        chk("change_tick1", tk[1], 32'h928);
        chk("change_busy1", bz[1], 32'h2C);
        chk("change_oclk1", oc[1], 32'hE30);
        chk("ratio1_tick2", tk[2], 32'h3FF8);
        chk("ratio1_oclk2", oc[2], 32'h1550);
        chk("ratio1_busy2", bz[2], 32'h0);

        // Out-of-range channel is accepted and dropped
        @(negedge input_clock);
        drive(1'b1, 2'd3, 8'd9);
        #1 chk("oor_ready", 32'(cfg.cfg_ready), 32'h1);
        @(negedge input_clock);
        cfg.cfg_valid = 1'b0;
        chk("oor_no_busy", 32'(busy), 32'h0);

        // Reset in the middle of a pending update
        drive(1'b1, 2'd1, 8'd5);
        #1 chk("pend_write_ready", 32'(cfg.cfg_ready), 32'h1);
        @(negedge input_clock);
        cfg.cfg_valid = 1'b0;
        chk("pend_before_reset", 32'(busy), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_oclk", 32'(output_clock), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        @(negedge input_clock);
        reset_n = 1'b1;
        clear_rec();
        for (int k = 1; k <= 12; k++) begin
            @(negedge input_clock);
            sample(k - 1);
        end
        chk("post_rst_no_tick", tk[0] | tk[1] | tk[2], 32'h0);
        chk("post_rst_oclk_low", oc[0] | oc[1] | oc[2], 32'h0);
        chk("post_rst_no_busy", bz[0] | bz[1] | bz[2], 32'h0);

        // Disable channel 0 running at ratio 5
        drive(1'b1, 2'd0, 8'd5);
        clear_rec();
        for (int k = 1; k <= 14; k++) begin
            @(negedge input_clock);
            sample(k - 1);
            if (k == 1) cfg.cfg_valid = 1'b0;
            if (k == 2) begin
                drive(1'b1, 2'd0, 8'd0);
                #1 chk("disable_write_ready", 32'(cfg.cfg_ready), 32'h1);
            end
            if (k == 3) cfg.cfg_valid = 1'b0;
        end
        chk("disable_tick0", tk[0], 32'h10);
        chk("disable_oclk0", oc[0], 32'h3FE0);
        chk("disable_busy0", bz[0], 32'h1C);

        // Zero written to an already disabled channel: handshake only
        @(negedge input_clock);
        drive(1'b1, 2'd0, 8'd0);
        #1 chk("noop_ready", 32'(cfg.cfg_ready), 32'h1);
        clear_rec();
        for (int k = 1; k <= 6; k++) begin
            @(negedge input_clock);
            sample(k - 1);
            if (k == 1) cfg.cfg_valid = 1'b0;
        end
        chk("noop_tick0", tk[0], 32'h0);
        chk("noop_busy0", bz[0], 32'h0);
        chk("noop_oclk0_held", oc[0], 32'h3F);

        // Maximum ratio 255 on channel 1
        drive(1'b1, 2'd1, 8'd255);
        n_ticks     = 0;
        first_tick  = 0;
        second_tick = 0;
        for (int k = 1; k <= 520; k++) begin
            @(negedge input_clock);
            if (k == 1) cfg.cfg_valid = 1'b0;
            if (tick[1]) begin
                n_ticks++;
                if (n_ticks == 1) first_tick = k;
                else if (n_ticks == 2) second_tick = k;
            end
        end
        chk("r255_tick_count", 32'(n_ticks), 32'd2);
        chk("r255_first_tick", 32'(first_tick), 32'd255);
        chk("r255_second_tick", 32'(second_tick), 32'd510);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
